// File: rtl/mux_nch_reg.sv
// mux_nch_reg: registered NCH-channel WIDTH-bit mux with held/round-robin channel register; `MUX_PARITY_EN adds YP
module mux_nch_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 CLK,
    input  logic                 RSTbar,
    input  logic [NCH*WIDTH-1:0] D,
    input  logic [SELW-1:0]      SEL,
    input  logic                 SEL_LD,
    input  logic                 SCAN,
    input  logic                 Gbar,
    output logic [WIDTH-1:0]     Y,
    output logic                 YV,
    output logic [SELW-1:0]      YCH,
    output logic [SELW-1:0]      CH,
`ifdef MUX_PARITY_EN
    output logic                 YP,
`endif
    output logic                 SERR
);
    localparam logic [SELW-1:0] CH_LAST = SELW'(NCH - 1);
    localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NCH);
    logic [WIDTH-1:0] chan [NCH];
    logic [WIDTH-1:0] y_q, y_d;
    logic [SELW-1:0]  ch_q, ch_d, ych_q, ych_d;
    logic             yv_q, yv_d, serr_q, serr_d, sel_ok;
    genvar g;
    for (g = 0; g < NCH; g++) begin : g_chan
        assign chan[g] = D[g*WIDTH +: WIDTH];
    end
    assign sel_ok = {1'b0, SEL} < NCH_W;
    // next state: output stage samples the pre-edge channel; channel update is load > bad load > scan > hold
    always_comb begin
        y_d    = Gbar ? '0 : chan[ch_q];
        yv_d   = !Gbar;
        ych_d  = Gbar ? ych_q : ch_q;
        ch_d   = Gbar                ? ch_q :
                 (SEL_LD && sel_ok)  ? SEL :
                 SEL_LD              ? ch_q :
                 SCAN                ? ((ch_q == CH_LAST) ? '0 : ch_q + SELW'(1)) :
                                       ch_q;
        serr_d = serr_q | (!Gbar && SEL_LD && !sel_ok);
    end
    // state registers with asynchronous clear
    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            y_q    <= '0;
            yv_q   <= 1'b0;
            ych_q  <= '0;
            ch_q   <= '0;
            serr_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            yv_q   <= yv_d;
            ych_q  <= ych_d;
            ch_q   <= ch_d;
            serr_q <= serr_d;
        end
    end
`ifdef MUX_PARITY_EN
    logic yp_q;
    // parity of the word loaded into Y; zero whenever Y is cleared
    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) yp_q <= 1'b0;
        else         yp_q <= ^y_d;
    end
    assign YP = yp_q;
`endif
    assign Y    = y_q;
    assign YV   = yv_q;
    assign YCH  = ych_q;
    assign CH   = ch_q;
    assign SERR = serr_q;
endmodule

// File: tb/tb_mux_nch_reg.sv
// tb_mux_nch_reg: scoreboard bench for NCH=4 and NCH=3 instances sharing clock, reset and controls
module tb_mux_nch_reg;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] d4;
    logic [1:0]  sel;
    logic        ld, scan, gbar;
    logic [7:0]  y4, y3;
    logic        yv4, yv3, serr4, serr3;
    logic [1:0]  ych4, ych3, ch4, ch3;
`ifdef MUX_PARITY_EN
    logic        yp4, yp3;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] y;
        logic       yv;
        logic [1:0] ych;
        logic [1:0] ch;
        logic       serr;
        logic       yp;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_ch[2];
    logic [1:0] m_ych[2];
    logic       m_serr[2];
    logic [1:0] seq3[7] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

    mux_nch_reg #(.WIDTH(8), .NCH(4), .SELW(2)) dut4 (
        .CLK(clk), .RSTbar(rst_n), .D(d4), .SEL(sel), .SEL_LD(ld), .SCAN(scan), .Gbar(gbar),
        .Y(y4), .YV(yv4), .YCH(ych4), .CH(ch4),
`ifdef MUX_PARITY_EN
        .YP(yp4),
`endif
        .SERR(serr4)
    );

    mux_nch_reg #(.WIDTH(8), .NCH(3), .SELW(2)) dut3 (
        .CLK(clk), .RSTbar(rst_n), .D(d4[23:0]), .SEL(sel), .SEL_LD(ld), .SCAN(scan), .Gbar(gbar),
        .Y(y3), .YV(yv3), .YCH(ych3), .CH(ch3),
`ifdef MUX_PARITY_EN
        .YP(yp3),
`endif
        .SERR(serr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t observe(input int k);
        exp_t o;
        o.y    = (k == 0) ? y4 : y3;
        o.yv   = (k == 0) ? yv4 : yv3;
        o.ych  = (k == 0) ? ych4 : ych3;
        o.ch   = (k == 0) ? ch4 : ch3;
        o.serr = (k == 0) ? serr4 : serr3;
`ifdef MUX_PARITY_EN
        o.yp   = (k == 0) ? yp4 : yp3;
`else
        o.yp   = 1'b0;
`endif
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ch[k]   = 2'd0;
            m_ych[k]  = 2'd0;
            m_serr[k] = 1'b0;
        end
    endtask

    task automatic step();
        exp_t e;
        int   nch;
        for (int k = 0; k < 2; k++) begin
            nch    = (k == 0) ? 4 : 3;
            e.y    = gbar ? 8'h00 : d4[int'(m_ch[k])*8 +: 8];
            e.yv   = !gbar;
            e.ych  = gbar ? m_ych[k] : m_ch[k];
            m_ych[k] = e.ych;
            if (!gbar) begin
                if (ld && int'(sel) < nch) m_ch[k] = sel;
                else if (ld) m_serr[k] = 1'b1;
                else if (scan) m_ch[k] = (m_ch[k] == 2'(nch - 1)) ? 2'd0 : m_ch[k] + 2'd1;
            end
            e.ch   = m_ch[k];
            e.serr = m_serr[k];
`ifdef MUX_PARITY_EN
            e.yp   = ^e.y;
`else
            e.yp   = 1'b0;
`endif
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            chk($sformatf("sb.nch%0d", (k == 0) ? 4 : 3), 32'(observe(k)), 32'(e));
        end
    endtask

    initial begin
        logic [1:0] prev;
        rst_n = 1'b0;
        d4 = 32'h44332211;
        sel = 2'd0; ld = 1'b0; scan = 1'b0; gbar = 1'b0;
        model_reset();
        #12;
        chk("reset.nch4", 32'(observe(0)), 32'h0);
        chk("reset.nch3", 32'(observe(1)), 32'h0);
        rst_n = 1'b1;

        step();
        chk("t1.y", 32'(y4), 32'h11);
        chk("t1.yv", 32'(yv4), 32'h1);
        chk("t1.ch", 32'(ch4), 32'h0);

        sel = 2'd2; ld = 1'b1;
        step();
        chk("t2.ch_k", 32'(ch4), 32'h2);
        chk("t2.y_k", 32'(y4), 32'h11);
        ld = 1'b0;
        step();
        chk("t2.y_k1", 32'(y4), 32'h33);
        chk("t2.ych_k1", 32'(ych4), 32'h2);

        sel = 2'd0; ld = 1'b1;
        step();
        ld = 1'b0; scan = 1'b1;
        prev = ch3;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("t3.ch[%0d]", i), 32'(ch3), 32'(seq3[i]));
            chk($sformatf("t3.ych[%0d]", i), 32'(ych3), 32'(prev));
            prev = ch3;
        end

        gbar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5.y_off", 32'(y3), 32'h0);
            chk("t5.yv_off", 32'(yv3), 32'h0);
            chk("t5.ch_hold", 32'(ch3), 32'h1);
        end
        gbar = 1'b0;
        step();
        chk("t5.y_on", 32'(y3), 32'h22);
        chk("t5.ch_on", 32'(ch3), 32'h2);

        #2 d4 = 32'hAAAAAAAA;
        #1 chk("dchg.y", 32'(y3), 32'h22);
        d4 = 32'h44332211;

        #1 rst_n = 1'b0;
        #1;
        chk("t6.ch", 32'(ch3), 32'h0);
        chk("t6.y", 32'(y3), 32'h0);
        chk("t6.yv", 32'(yv3), 32'h0);
        chk("t6.nch4", 32'(observe(0)), 32'h0);
        rst_n = 1'b1;
        model_reset();
        d4 = 32'h44332207;
        step();
        chk("t6.y_after", 32'(y3), 32'h07);
`ifdef MUX_PARITY_EN
        chk("t6.yp", 32'(yp3), 32'h1);
`endif

        scan = 1'b0; sel = 2'd3; ld = 1'b1;
        step();
        chk("t4.serr3", 32'(serr3), 32'h1);
        chk("t4.ch3_hold", 32'(ch3), 32'h1);
        chk("t4.serr4", 32'(serr4), 32'h0);
        chk("t4.ch4_load", 32'(ch4), 32'h3);
        sel = 2'd1;
        step();
        chk("t4.serr_sticky", 32'(serr3), 32'h1);
        chk("t4.ch3_load", 32'(ch3), 32'h1);
        sel = 2'd2; scan = 1'b1;
        step();
        chk("ldscan.ch3", 32'(ch3), 32'h2);
        ld = 1'b0; scan = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("t4.serr_clr", 32'(serr3), 32'h0);
        rst_n = 1'b1;
        model_reset();

        gbar = 1'b1; sel = 2'd3; ld = 1'b1;
        step();
        chk("gbar.ld_ignored", 32'(serr3), 32'h0);
        gbar = 1'b0; ld = 1'b0; scan = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("end.sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
